// File: rtl/led_frame_loader_pkg.sv
// ----------------------------------------------------------------------------
// led_frame_pkg
// Shared definitions for the LED frame loader: the loader state encoding,
// the default frame start byte, and the bytes-per-frame derivation.
// No ports (package).
// ----------------------------------------------------------------------------
package led_frame_pkg;

    // Loader states. IDLE hunts for the header, PAYLOAD/CHECKSUM collect a
    // frame, WAIT_READY/START hand a committed frame to the LED driver.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PAYLOAD    = 3'd1,
        CHECKSUM   = 3'd2,
        WAIT_READY = 3'd3,
        START      = 3'd4
    } state_t;

    // Byte that opens every frame on the UART stream.
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

    // Each LED takes three colour bytes (G, R, B).
    function automatic int frame_bytes(input int num_leds);
        return 3 * num_leds;
    endfunction

endpackage

// File: rtl/led_frame_loader_if.sv
// ----------------------------------------------------------------------------
// led_frame_loader_if
// Bundles the UART byte stream, the LED driver handshake and the loader's
// status outputs.
//   i_Data/i_Valid  : received UART byte and its one-cycle strobe
//   i_Ready         : LED driver idle and able to accept a start
//   o_Frame         : committed GRB frame, LED0 in the MSBs
//   o_Start         : start request to the LED driver
//   o_Busy          : loader is not idle
//   o_Error         : one-cycle pulse on checksum mismatch or timeout
//   o_Overrun       : one-cycle pulse when a byte is dropped during handoff
//   o_FrameCount    : frames delivered, wrapping at 256
// slave  = the loader, master = whoever feeds bytes and plays the driver.
// ----------------------------------------------------------------------------
interface led_frame_loader_if #(
    parameter int NUM_LEDS = 3
);

    logic [7:0]            i_Data;
    logic                  i_Valid;
    logic                  i_Ready;
    logic [24*NUM_LEDS-1:0] o_Frame;
    logic                  o_Start;
    logic                  o_Busy;
    logic                  o_Error;
    logic                  o_Overrun;
    logic [7:0]            o_FrameCount;

    modport slave (
        input  i_Data, i_Valid, i_Ready,
        output o_Frame, o_Start, o_Busy, o_Error, o_Overrun, o_FrameCount
    );

    modport master (
        output i_Data, i_Valid, i_Ready,
        input  o_Frame, o_Start, o_Busy, o_Error, o_Overrun, o_FrameCount
    );

endinterface

// File: rtl/led_frame_loader_timeout.sv
// ----------------------------------------------------------------------------
// frame_timeout
// Inter-byte watchdog for the frame loader. Counts enabled cycles since the
// last clear and flags when TIMEOUT_CYCLES has been reached. The count
// saturates so a long stall can never wrap back into a "healthy" value.
//   i_Clock  : system clock
//   i_Reset  : asynchronous, active-high reset
//   clear    : restart the count (a byte arrived, or not inside a frame)
//   enable   : count this cycle
//   expired  : count has reached TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Saturating counter: clear wins over enable, and once LIMIT is reached
    // the value holds until the next clear.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/led_frame_loader.sv
// ----------------------------------------------------------------------------
// led_frame_loader
// Assembles LED frames from a UART byte stream and hands them to an LED
// driver. A frame is HEADER, 3*NUM_LEDS payload bytes, then one checksum
// byte equal to the XOR of the payload. Payload is collected in a shadow
// buffer and only copied to o_Frame once the checksum matches, so the driver
// never sees a partial or corrupt frame.
//   i_Clock : system clock
//   i_Reset : asynchronous, active-high reset
//   bus     : led_frame_loader_if slave port (byte stream, driver handshake,
//             status outputs)
// ----------------------------------------------------------------------------
module led_frame_loader
    import led_frame_pkg::*;
#(
    parameter int         NUM_LEDS       = 3,
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input logic               i_Clock,
    input logic               i_Reset,
    led_frame_loader_if.slave bus
);

    localparam int FRAME_BYTES = frame_bytes(NUM_LEDS);
    localparam int FRAME_W     = 8 * FRAME_BYTES;
    localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_t             state;
    logic [IDX_W-1:0]   byte_idx;
    logic [7:0]         running_xor;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] frame;
    logic               start_q;
    logic               error_q;
    logic               overrun_q;
    logic [7:0]         frame_count;

    logic               in_frame;
    logic               timer_clear;
    logic               timer_expired;

    // The watchdog only matters while a frame is being received; everywhere
    // else it is held cleared so it starts fresh after each header.
    assign in_frame    = (state == PAYLOAD) || (state == CHECKSUM);
    assign timer_clear = bus.i_Valid || !in_frame;

    frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .clear   (timer_clear),
        .enable  (in_frame),
        .expired (timer_expired)
    );

    // Main loader FSM. Error and overrun are single-cycle pulses, so they are
    // defaulted low each cycle. In PAYLOAD and CHECKSUM an arriving byte is
    // checked before the timeout, which lets a byte landing on the expiry
    // cycle still be accepted. A header value inside the payload is plain
    // data; there is no mid-frame resync.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state       <= IDLE;
            byte_idx    <= '0;
            running_xor <= '0;
            shadow      <= '0;
            frame       <= '0;
            start_q     <= 1'b0;
            error_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_count <= '0;
        end else begin
            error_q   <= 1'b0;
            overrun_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_Valid && (bus.i_Data == HEADER)) begin
                        state       <= PAYLOAD;
                        byte_idx    <= '0;
                        running_xor <= '0;
                    end
                end

                PAYLOAD: begin
                    if (bus.i_Valid) begin
                        // Byte 0 lands in the top byte of the buffer.
                        shadow[FRAME_W - 8 - 8 * int'(byte_idx) +: 8] <= bus.i_Data;
                        running_xor <= running_xor ^ bus.i_Data;
                        if (byte_idx == LAST_IDX) begin
                            state    <= CHECKSUM;
                            byte_idx <= '0;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end else if (timer_expired) begin
                        error_q     <= 1'b1;
                        state       <= IDLE;
                        shadow      <= '0;
                        byte_idx    <= '0;
                        running_xor <= '0;
                    end
                end

                CHECKSUM: begin
                    if (bus.i_Valid) begin
                        if (bus.i_Data == running_xor) begin
                            frame <= shadow;
                            state <= WAIT_READY;
                        end else begin
                            error_q <= 1'b1;
                            state   <= IDLE;
                            shadow  <= '0;
                        end
                        running_xor <= '0;
                    end else if (timer_expired) begin
                        error_q     <= 1'b1;
                        state       <= IDLE;
                        shadow      <= '0;
                        running_xor <= '0;
                    end
                end

                WAIT_READY: begin
                    if (bus.i_Valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (bus.i_Ready) begin
                        start_q <= 1'b1;
                        state   <= START;
                    end
                end

                START: begin
                    // Hold the request until the driver shows it has taken
                    // the frame by dropping ready.
                    if (bus.i_Valid) begin
                        overrun_q <= 1'b1;
                    end
                    if (!bus.i_Ready) begin
                        start_q     <= 1'b0;
                        frame_count <= frame_count + 8'd1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Frame      = frame;
    assign bus.o_Start      = start_q;
    assign bus.o_Busy       = (state != IDLE);
    assign bus.o_Error      = error_q;
    assign bus.o_Overrun    = overrun_q;
    assign bus.o_FrameCount = frame_count;

endmodule

// File: tb/tb_led_frame_loader.sv
// ----------------------------------------------------------------------------
// tb_led_frame_loader
// Self-checking bench for led_frame_loader. Frames are described as an array
// of payload bytes; the expected frame word, checksum and delivery count are
// derived from that array with plain arithmetic. Inputs change on the falling
// edge and outputs are read on the falling edge or just after the rising one.
// ----------------------------------------------------------------------------
module tb_led_frame_loader;

    localparam int         NL  = 3;
    localparam int         FB  = 3 * NL;
    localparam int         FW  = 24 * NL;
    localparam int         T   = 40;
    localparam logic [7:0] HDR = 8'hA5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_frame_loader_if #(.NUM_LEDS(NL)) bus ();

    led_frame_loader #(
        .NUM_LEDS       (NL),
        .HEADER         (HDR),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    int total   = 0;
    int bad     = 0;
    int errSeen = 0;
    int ovrSeen = 0;

    logic [FW-1:0] expFrame;
    int            expCount;
    logic [7:0]    payload [FB];

    // Pulse counters, sampled just after each rising edge so a pulse that
    // lasts more than one cycle is counted more than once.
    always begin
        @(posedge clk);
        #1;
        if (rst !== 1'b1) begin
            if (bus.o_Error === 1'b1)   errSeen++;
            if (bus.o_Overrun === 1'b1) ovrSeen++;
        end
    end

    // Guard against a hung run.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s differs", tag);
        end
    endtask

    // Present one byte for exactly one cycle; called and returns on a falling edge.
    task automatic applyStimulus(input logic [7:0] b);
        bus.i_Data  = b;
        bus.i_Valid = 1'b1;
        @(negedge clk);
        bus.i_Valid = 1'b0;
        bus.i_Data  = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] modelChecksum();
        logic [7:0] r = 8'h00;
        for (int i = 0; i < FB; i++) r = r ^ payload[i];
        return r;
    endfunction

    function automatic logic [FW-1:0] modelFrame();
        logic [FW-1:0] r = '0;
        for (int i = 0; i < FB; i++) r = (r << 8) | FW'(payload[i]);
        return r;
    endfunction

    task automatic randomPayload();
        for (int i = 0; i < FB; i++) payload[i] = 8'($urandom);
    endtask

    task automatic sendFrame(input logic [7:0] ck, input int gapMax);
        applyStimulus(HDR);
        for (int i = 0; i < FB; i++) begin
            idle($urandom_range(0, gapMax));
            applyStimulus(payload[i]);
        end
        idle($urandom_range(0, gapMax));
        applyStimulus(ck);
    endtask

    // Play the LED driver: raise ready, wait for start, then drop ready and
    // expect start to fall on the next edge with the count advanced.
    task automatic handshake(input string tag);
        int n = 0;
        bus.i_Ready = 1'b1;
        while (bus.o_Start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_start_rise"}, bus.o_Start, 1);
        @(negedge clk);
        checkOutput({tag, "_start_hold"}, bus.o_Start, 1);
        bus.i_Ready = 1'b0;
        @(negedge clk);
        expCount = (expCount + 1) % 256;
        checkOutput({tag, "_start_drop"}, bus.o_Start, 0);
        checkOutput({tag, "_count"}, bus.o_FrameCount, expCount);
        checkOutput({tag, "_busy_after"}, bus.o_Busy, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_frame"},   bus.o_Frame, 0);
        checkOutput({tag, "_start"},   bus.o_Start, 0);
        checkOutput({tag, "_busy"},    bus.o_Busy, 0);
        checkOutput({tag, "_error"},   bus.o_Error, 0);
        checkOutput({tag, "_overrun"}, bus.o_Overrun, 0);
        checkOutput({tag, "_count"},   bus.o_FrameCount, 0);
    endtask

    initial begin
        int eb;
        int ob;
        logic [7:0] b;
        logic [7:0] x;
        logic [7:0] ck;
        bit ok;

        rst         = 1'b1;
        bus.i_Valid = 1'b0;
        bus.i_Ready = 1'b0;
        bus.i_Data  = 8'h00;
        expFrame    = '0;
        expCount    = 0;

        // ---- reset state ----
        @(negedge clk);
        checkResetState("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset released");

        // ---- known-good frame with driver already ready ----
        payload = '{8'h11, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h11};
        bus.i_Ready = 1'b1;
        eb = errSeen;
        sendFrame(8'hFF, 0);
        expFrame = 72'h110000_00FF00_000011;
        checkOutput("good_frame", bus.o_Frame, expFrame);
        checkOutput("good_busy", bus.o_Busy, 1);
        handshake("good");
        checkOutput("good_no_error", errSeen, eb);

        // ---- same frame, wrong checksum ----
        bus.i_Ready = 1'b1;
        eb = errSeen;
        sendFrame(8'h00, 0);
        checkOutput("badck_error_now", bus.o_Error, 1);
        idle(3);
        checkOutput("badck_error_single", errSeen, eb + 1);
        checkOutput("badck_error_low", bus.o_Error, 0);
        checkOutput("badck_frame_kept", bus.o_Frame, expFrame);
        checkOutput("badck_start", bus.o_Start, 0);
        checkOutput("badck_busy", bus.o_Busy, 0);
        bus.i_Ready = 1'b0;

        // ---- timeout after 4 payload bytes ----
        eb = errSeen;
        applyStimulus(HDR);
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
        idle(T);
        checkOutput("tmo_not_yet_busy", bus.o_Busy, 1);
        checkOutput("tmo_not_yet_error", bus.o_Error, 0);
        idle(1);
        checkOutput("tmo_error", bus.o_Error, 1);
        checkOutput("tmo_busy", bus.o_Busy, 0);
        idle(2);
        checkOutput("tmo_error_single", errSeen, eb + 1);
        checkOutput("tmo_frame_kept", bus.o_Frame, expFrame);

        // ---- longest allowed gap, header value as payload data ----
        randomPayload();
        payload[4] = HDR;
        eb = errSeen;
        applyStimulus(HDR);
        for (int i = 0; i < FB; i++) begin
            if (i == 3) idle(T);
            applyStimulus(payload[i]);
        end
        applyStimulus(modelChecksum());
        expFrame = modelFrame();
        checkOutput("gap_frame", bus.o_Frame, expFrame);
        checkOutput("gap_no_error", errSeen, eb);
        handshake("gap");

        // ---- overrun while waiting for the driver ----
        randomPayload();
        sendFrame(modelChecksum(), 2);
        expFrame = modelFrame();
        checkOutput("ovr_frame", bus.o_Frame, expFrame);
        idle(2);
        checkOutput("ovr_start_wait", bus.o_Start, 0);
        ob = ovrSeen;
        applyStimulus(8'h3C);
        checkOutput("ovr_pulse", bus.o_Overrun, 1);
        checkOutput("ovr_busy", bus.o_Busy, 1);
        idle(1);
        checkOutput("ovr_pulse_low", bus.o_Overrun, 0);
        checkOutput("ovr_single", ovrSeen, ob + 1);
        idle(3);
        checkOutput("ovr_start_still", bus.o_Start, 0);
        checkOutput("ovr_frame_kept", bus.o_Frame, expFrame);
        handshake("ovr");

        // ---- randomized frames ----
        for (int f = 0; f < 24; f++) begin
            randomPayload();
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                if (b == HDR) b = 8'h5A;
                applyStimulus(b);
            end
            ok = ($urandom_range(0, 3) != 0);
            x  = modelChecksum();
            ck = ok ? x : (x ^ 8'($urandom_range(1, 255)));
            eb = errSeen;
            sendFrame(ck, 3);
            if (ok) begin
                expFrame = modelFrame();
                checkOutput("rnd_frame", bus.o_Frame, expFrame);
                checkOutput("rnd_busy", bus.o_Busy, 1);
                if ($urandom_range(0, 1) == 1) begin
                    ob = ovrSeen;
                    applyStimulus(8'($urandom));
                    idle(1);
                    checkOutput("rnd_overrun", ovrSeen, ob + 1);
                end
                handshake("rnd");
                checkOutput("rnd_no_error", errSeen, eb);
            end else begin
                idle(2);
                checkOutput("rnd_bad_frame_kept", bus.o_Frame, expFrame);
                checkOutput("rnd_bad_busy", bus.o_Busy, 0);
                checkOutput("rnd_bad_error", errSeen, eb + 1);
            end
        end

        // ---- reset in PAYLOAD ----
        applyStimulus(HDR);
        for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));
        #2 rst = 1'b1;
        #1;
        expFrame = '0;
        expCount = 0;
        checkResetState("rst_payload");
        @(negedge clk);
        rst = 1'b0;
        randomPayload();
        sendFrame(modelChecksum(), 1);
        expFrame = modelFrame();
        checkOutput("rst_payload_next_frame", bus.o_Frame, expFrame);
        handshake("rst_payload_next");

        // ---- reset in START ----
        randomPayload();
        sendFrame(modelChecksum(), 1);
        bus.i_Ready = 1'b1;
        idle(2);
        checkOutput("rst_start_pre", bus.o_Start, 1);
        #2 rst = 1'b1;
        #1;
        expFrame = '0;
        expCount = 0;
        checkResetState("rst_start");
        @(negedge clk);
        rst = 1'b0;
        bus.i_Ready = 1'b0;
        randomPayload();
        sendFrame(modelChecksum(), 1);
        expFrame = modelFrame();
        checkOutput("rst_start_next_frame", bus.o_Frame, expFrame);
        handshake("rst_start_next");

        // ---- frame counter wrap ----
        for (int f = 0; f < 255; f++) begin
            randomPayload();
            sendFrame(modelChecksum(), 0);
            expFrame = modelFrame();
            checkOutput("wrap_frame", bus.o_Frame, expFrame);
            handshake("wrap");
        end
        checkOutput("wrap_to_zero", bus.o_FrameCount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_frame_loader.md
LED_FRAME_LOADER -- requirements
Module: led_frame_loader

Interface
REQ-001 Parameter NUM_LEDS, 3, number of LEDs per frame; FRAME_BYTES = 3*NUM_LEDS.
REQ-002 Parameter HEADER, 8'hA5, frame start byte.
REQ-003 Parameter TIMEOUT_CYCLES, 100000, maximum allowed i_Clock cycles between bytes inside a frame.
REQ-004 i_Clock  in  1  system clock.
REQ-005 i_Reset  in  1  reset; asynchronous, active-high.
REQ-006 i_Data  in  8  received UART byte.
REQ-007 i_Valid  in  1  one-cycle strobe; i_Data is valid.
REQ-008 i_Ready  in  1  downstream LED driver idle and able to accept a start.
REQ-009 o_Frame  out  24*NUM_LEDS  GRB frame, LED0 in MSBs; stable except at commit.
REQ-010 o_Start  out  1  start request to the LED driver.
REQ-011 o_Busy  out  1  high in any state other than IDLE.
REQ-012 o_Error  out  1  one-cycle pulse on checksum mismatch or timeout.
REQ-013 o_Overrun  out  1  one-cycle pulse when a byte is dropped in WAIT_READY or START.
REQ-014 o_FrameCount  out  8  frames delivered, wraps 255->0.

Function
REQ-015 States SHALL be IDLE, PAYLOAD, CHECKSUM, WAIT_READY, START.
REQ-016 IDLE: i_Valid with i_Data==HEADER -> PAYLOAD, byte index=0, running XOR=0; any other byte ignored, no error.
REQ-017 PAYLOAD: each i_Valid byte stored in shadow buffer at index (index 0 -> shadow MSBs), XOR updated, index incremented; the byte at index FRAME_BYTES-1 -> CHECKSUM.
REQ-018 A HEADER value inside PAYLOAD SHALL be treated as data, not as resync.
REQ-019 CHECKSUM: i_Valid byte equal to XOR of all payload bytes -> o_Frame loaded from shadow on the next edge, -> WAIT_READY; mismatch -> o_Error pulse, o_Frame unchanged, -> IDLE.
REQ-020 WAIT_READY: i_Ready=1 -> o_Start=1 on the next edge, -> START.
REQ-021 START: o_Start held 1 until i_Ready samples 0; on that edge o_Start=0, o_FrameCount+1, -> IDLE.
REQ-022 Inter-byte counter runs in PAYLOAD and CHECKSUM, cleared on every i_Valid; reaching TIMEOUT_CYCLES -> o_Error pulse, -> IDLE, shadow discarded.
REQ-023 i_Valid and timeout expiry in the same cycle: byte is accepted, no timeout.
REQ-024 i_Valid in WAIT_READY or START: byte discarded, o_Overrun pulse, state unchanged.
REQ-025 Inter-byte counter SHALL saturate and not wrap; width = clog2(TIMEOUT_CYCLES+1).
REQ-026 All outputs registered; o_Busy derived from registered state.

Reset
REQ-027 i_Reset SHALL force state=IDLE, o_Frame=0, o_Start=0, o_Error=0, o_Overrun=0, o_FrameCount=0, index=0, XOR=0, timeout counter=0.
REQ-028 Reset mid-frame or mid-START SHALL discard the shadow buffer and drop o_Start immediately.

Structure
REQ-029 Package led_frame_pkg SHALL hold the state encoding, the default HEADER, and the FRAME_BYTES derivation.
REQ-030 The inter-byte timer SHALL be a sub-module frame_timeout (inputs clear and enable; output expired).

Verification
REQ-031 Send A5,11,00,00,00,FF,00,00,00,11,FF (checksum = XOR of payload) with i_Ready=1 -> o_Frame=72'h110000_00FF00_000011, o_Start rises, drops one cycle after i_Ready falls, o_FrameCount=1.
REQ-032 Same frame with checksum 00 -> single-cycle o_Error pulse, o_Frame unchanged, o_Start never asserted.
REQ-033 A5 plus 4 payload bytes, then silence for TIMEOUT_CYCLES -> o_Error pulse, o_Busy=0; next valid frame is accepted normally.
REQ-034 Valid frame with i_Ready=0; send byte 3C while in WAIT_READY -> o_Overrun pulse, o_Start stays 0 until i_Ready=1.
REQ-035 Assert i_Reset while in PAYLOAD and again while in START -> all outputs at reset values within the same cycle; a subsequent frame completes correctly.
REQ-036 Deliver 256 valid frames -> o_FrameCount wraps to 0.
